// File: rtl/ov7670_pkg.sv
// OV7670 capture shared defaults, FSM encoding and frame-size helper.
// Optional build macro: OV7670_CAPTURE_DECIMATE_EN (2x2 decimation).
package ov7670_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int FRAME_PIX    = H_ACTIVE_DEF * V_ACTIVE_DEF;

  localparam logic [1:0] WAIT_CFG   = 2'd0;
  localparam logic [1:0] WAIT_VSYNC = 2'd1;
  localparam logic [1:0] ACTIVE     = 2'd2;

  function automatic int pixLimit(input int h, input int v);
`ifdef OV7670_CAPTURE_DECIMATE_EN
    return (h / 2) * (v / 2) - 1;
`else
    return h * v - 1;
`endif
  endfunction

endpackage

// File: rtl/ov7670_sync_edge.sv
// Two-flop synchroniser plus a third flop for edge detection.
// Level and edges are taken from stage 2 so they stay mutually aligned.
module ov7670_sync_edge (
  input  logic iCLK,
  input  logic iRST_N,
  input  logic iD,
  output logic oLvl,
  output logic oRise,
  output logic oFall
);

  logic [2:0] sr;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) sr <= '0;
    else         sr <= {sr[1:0], iD};
  end

  assign oLvl  = sr[1];
  assign oRise = sr[1] & ~sr[2];
  assign oFall = ~sr[1] & sr[2];

endmodule

// File: rtl/ov7670_capture.sv
// OV7670 byte-stream to RGB565 pixel writer with frame strobes.
// Optional build macro: OV7670_CAPTURE_DECIMATE_EN (keep even px of even lines).
module ov7670_capture
  import ov7670_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int ADDR_W   = 19
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iCONFIG_DONE,
  input  logic              iCAM_PCLK,
  input  logic              iCAM_VSYNC,
  input  logic              iCAM_HREF,
  input  logic [7:0]        iCAM_DATA,
  output logic [15:0]       oPIX_DATA,
  output logic              oPIX_VALID,
  output logic [ADDR_W-1:0] oPIX_ADDR,
  output logic              oFRAME_START,
  output logic              oFRAME_DONE,
  output logic              oOVERRUN
);

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(pixLimit(H_ACTIVE, V_ACTIVE));

  logic pclkLvl, pclkRise, pclkFall;
  logic vsLvl, vsRise, vsFall;
  logic hrefLvl, hrefRise, hrefFall;
  logic unusedSync;

  ov7670_sync_edge uPclk (
    .iCLK(iCLK), .iRST_N(iRST_N), .iD(iCAM_PCLK),
    .oLvl(pclkLvl), .oRise(pclkRise), .oFall(pclkFall));
  ov7670_sync_edge uVsync (
    .iCLK(iCLK), .iRST_N(iRST_N), .iD(iCAM_VSYNC),
    .oLvl(vsLvl), .oRise(vsRise), .oFall(vsFall));
  ov7670_sync_edge uHref (
    .iCLK(iCLK), .iRST_N(iRST_N), .iD(iCAM_HREF),
    .oLvl(hrefLvl), .oRise(hrefRise), .oFall(hrefFall));

  assign unusedSync = ^{pclkLvl, pclkFall, vsLvl, hrefRise};

  logic [7:0] d1, d2;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      d1 <= '0;
      d2 <= '0;
    end else begin
      d1 <= iCAM_DATA;
      d2 <= d1;
    end
  end

  logic [1:0] state;
  logic phase, full;
  logic pend1, pend2, done1, done2;
  logic byteEdge, complete, keep, accept;

  assign byteEdge = (state == ACTIVE) & pclkRise & hrefLvl;
  assign complete = byteEdge & phase;
  assign accept   = complete & keep & ~full;

`ifdef OV7670_CAPTURE_DECIMATE_EN
  logic xOdd, yOdd;

  assign keep = ~xOdd & ~yOdd;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      xOdd <= 1'b0;
      yOdd <= 1'b0;
    end else if (state == WAIT_VSYNC && vsFall) begin
      xOdd <= 1'b0;
      yOdd <= 1'b0;
    end else if (state == ACTIVE && hrefFall) begin
      xOdd <= 1'b0;
      yOdd <= ~yOdd;
    end else if (complete) begin
      xOdd <= ~xOdd;
    end
  end
`else
  assign keep = 1'b1;
`endif

  // Valid and frame-done share a 2-deep delay so a pixel completing
  // alongside VSYNC rise emerges in the same cycle as oFRAME_DONE.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state        <= WAIT_CFG;
      phase        <= 1'b0;
      full         <= 1'b0;
      pend1        <= 1'b0;
      pend2        <= 1'b0;
      done1        <= 1'b0;
      done2        <= 1'b0;
      oPIX_DATA    <= '0;
      oPIX_ADDR    <= '0;
      oPIX_VALID   <= 1'b0;
      oFRAME_START <= 1'b0;
      oFRAME_DONE  <= 1'b0;
      oOVERRUN     <= 1'b0;
    end else if (!iCONFIG_DONE) begin
      state        <= WAIT_CFG;
      phase        <= 1'b0;
      pend1        <= 1'b0;
      pend2        <= 1'b0;
      done1        <= 1'b0;
      done2        <= 1'b0;
      oPIX_VALID   <= 1'b0;
      oFRAME_START <= 1'b0;
      oFRAME_DONE  <= 1'b0;
    end else begin
      pend1        <= accept;
      pend2        <= pend1;
      oPIX_VALID   <= pend2;
      done1        <= 1'b0;
      done2        <= done1;
      oFRAME_DONE  <= done2;
      oFRAME_START <= 1'b0;
      if (oPIX_VALID) begin
        if (oPIX_ADDR == LAST) full <= 1'b1;
        else oPIX_ADDR <= oPIX_ADDR + ADDR_W'(1);
      end
      if (byteEdge && !phase) oPIX_DATA[15:8] <= d2;
      if (accept) oPIX_DATA[7:0] <= d2;
      if (complete && keep && full) oOVERRUN <= 1'b1;
      if (byteEdge) phase <= ~phase;
      if (hrefFall) phase <= 1'b0;
      unique case (state)
        WAIT_CFG: state <= WAIT_VSYNC;
        WAIT_VSYNC: begin
          if (vsFall) begin
            state        <= ACTIVE;
            oFRAME_START <= 1'b1;
            oPIX_ADDR    <= '0;
            full         <= 1'b0;
            oOVERRUN     <= 1'b0;
            phase        <= 1'b0;
          end
        end
        ACTIVE: begin
          if (vsRise) begin
            state <= WAIT_VSYNC;
            done1 <= 1'b1;
          end
        end
        default: state <= WAIT_CFG;
      endcase
    end
  end

endmodule

// File: tb/tb_ov7670_capture.sv
// Randomised bench for ov7670_capture against a frame-level pixel model.
// Honours OV7670_CAPTURE_DECIMATE_EN when compiled with it.
module tb_ov7670_capture;

  localparam int H  = 8;
  localparam int V  = 4;
  localparam int AW = 5;
`ifdef OV7670_CAPTURE_DECIMATE_EN
  localparam int LIMIT = (H / 2) * (V / 2) - 1;
`else
  localparam int LIMIT = H * V - 1;
`endif

  typedef logic [7:0] bq_t[$];

  logic          iCLK = 1'b0;
  logic          iRST_N;
  logic          iCONFIG_DONE;
  logic          iCAM_PCLK;
  logic          iCAM_VSYNC;
  logic          iCAM_HREF;
  logic [7:0]    iCAM_DATA;
  logic [15:0]   oPIX_DATA;
  logic          oPIX_VALID;
  logic [AW-1:0] oPIX_ADDR;
  logic          oFRAME_START;
  logic          oFRAME_DONE;
  logic          oOVERRUN;

  ov7670_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iCONFIG_DONE(iCONFIG_DONE),
    .iCAM_PCLK(iCAM_PCLK), .iCAM_VSYNC(iCAM_VSYNC),
    .iCAM_HREF(iCAM_HREF), .iCAM_DATA(iCAM_DATA),
    .oPIX_DATA(oPIX_DATA), .oPIX_VALID(oPIX_VALID),
    .oPIX_ADDR(oPIX_ADDR), .oFRAME_START(oFRAME_START),
    .oFRAME_DONE(oFRAME_DONE), .oOVERRUN(oOVERRUN));

  always #5 iCLK = ~iCLK;

  int nChecks = 0;
  int nErrs   = 0;

  task automatic checkEq(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: expected pixel writes in order
  int          qA[$];
  logic [15:0] qD[$];
  int mAddr, mLine;
  bit mOvr;

  task automatic modelPix(input logic [7:0] hi, input logic [7:0] lo,
                          input int x);
    bit keep = 1'b1;
`ifdef OV7670_CAPTURE_DECIMATE_EN
    keep = (x % 2 == 0) && (mLine % 2 == 0);
`endif
    if (keep) begin
      if (mAddr <= LIMIT) begin
        qA.push_back(mAddr);
        qD.push_back({hi, lo});
        mAddr++;
      end else begin
        mOvr = 1'b1;
      end
    end
  endtask

  int nValid = 0, nStart = 0, nDone = 0, lastAddr = -1;

  always @(negedge iCLK) begin
    if (oFRAME_START) nStart++;
    if (oFRAME_DONE) nDone++;
    if (oPIX_VALID) begin
      nValid++;
      lastAddr = int'(oPIX_ADDR);
      if (qA.size() == 0) begin
        checkEq("extra_strobe", 32'd1, 32'd0);
      end else begin
        checkEq("pix_addr", 32'(oPIX_ADDR), 32'(qA.pop_front()));
        checkEq("pix_data", 32'(oPIX_DATA), 32'(qD.pop_front()));
      end
    end
  end

  task automatic camByte(input logic [7:0] b);
    iCAM_DATA = b;
    #20 iCAM_PCLK = 1'b1;
    #20 iCAM_PCLK = 1'b0;
  endtask

  task automatic sendLine(input bq_t b, input bit mdl);
    if (mdl)
      for (int i = 0; i < b.size() / 2; i++)
        modelPix(b[2*i], b[2*i+1], i);
    iCAM_HREF = 1'b1;
    #30;
    foreach (b[i]) camByte(b[i]);
    #10 iCAM_HREF = 1'b0;
    #60;
    if (mdl) mLine++;
  endtask

  function automatic bq_t mkLine(input int n, input bit pat);
    bq_t q;
    for (int i = 0; i < n; i++)
      if (pat) q.push_back((i % 2 == 0) ? 8'hA5 : 8'h3C);
      else     q.push_back(8'($urandom));
    return q;
  endfunction

  task automatic frameBegin(input bit mdl);
    iCAM_VSYNC = 1'b0;
    #100;
    if (mdl) begin
      mAddr = 0;
      mLine = 0;
      mOvr  = 1'b0;
    end
  endtask

  task automatic frameEnd;
    #20 iCAM_VSYNC = 1'b1;
    #200;
  endtask

  task automatic fullFrame(input int ppl, input bit pat, input bit mdl);
    frameBegin(mdl);
    for (int l = 0; l < V; l++) sendLine(mkLine(2 * ppl, pat), mdl);
    frameEnd();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int s0, f0, d0, n;
    bit found;
    bq_t b;
    iRST_N = 1'b0; iCONFIG_DONE = 1'b0; iCAM_PCLK = 1'b0;
    iCAM_VSYNC = 1'b1; iCAM_HREF = 1'b0; iCAM_DATA = 8'h00;
    #53;
    @(negedge iCLK);
    checkEq("rst_valid", 32'(oPIX_VALID), 0);
    checkEq("rst_addr", 32'(oPIX_ADDR), 0);
    checkEq("rst_data", 32'(oPIX_DATA), 0);
    checkEq("rst_strobes", 32'({oFRAME_START, oFRAME_DONE}), 0);
    checkEq("rst_ovr", 32'(oOVERRUN), 0);
    iRST_N = 1'b1;
    #40;

    s0 = nValid; f0 = nStart;
    fullFrame(H, 1'b0, 1'b0);
    checkEq("cfgoff_valid", 32'(nValid - s0), 0);
    checkEq("cfgoff_start", 32'(nStart - f0), 0);

    iCONFIG_DONE = 1'b1;
    #100;

    for (int k = 0; k < 3; k++) begin
      d0 = nDone; f0 = nStart;
      fullFrame(H, k == 0, 1'b1);
      checkEq("frame_drain", 32'(qA.size()), 0);
      checkEq("frame_done", 32'(nDone - d0), 1);
      checkEq("frame_start", 32'(nStart - f0), 1);
      checkEq("frame_last", 32'(lastAddr), 32'(LIMIT));
      checkEq("frame_ovr", 32'(oOVERRUN), 32'(mOvr));
    end

    frameBegin(1'b1);
    b = '{8'h11, 8'h22, 8'h33};
    sendLine(b, 1'b1);
    b = '{8'h44, 8'h55};
    sendLine(b, 1'b1);
    frameEnd();
    checkEq("odd_drain", 32'(qA.size()), 0);

    fullFrame(H + 1, 1'b0, 1'b1);
    checkEq("ovr_set", 32'(oOVERRUN), 1);
    checkEq("ovr_last", 32'(lastAddr), 32'(LIMIT));
    frameBegin(1'b1);
    checkEq("ovr_clr", 32'(oOVERRUN), 0);
    for (int l = 0; l < V; l++) sendLine(mkLine(2 * H, 1'b0), 1'b1);
    frameEnd();
    checkEq("ovr_drain", 32'(qA.size()), 0);

    frameBegin(1'b1);
    iCAM_HREF = 1'b1;
    #30;
    modelPix(8'hC3, 8'h5A, 0);
    camByte(8'hC3);
    iCAM_DATA = 8'h5A;
    #5;
    @(posedge iCLK);
    #2 iCAM_PCLK = 1'b1;
    n = 0; found = 1'b0;
    for (int i = 1; i <= 10 && !found; i++) begin
      @(posedge iCLK);
      #1;
      if (oPIX_VALID) begin
        found = 1'b1;
        n = i;
      end
    end
    checkEq("latency", 32'(n), 5);
    #20 iCAM_PCLK = 1'b0;
    #10 iCAM_HREF = 1'b0;
    #60;
    mLine++;
    frameEnd();
    checkEq("lat_drain", 32'(qA.size()), 0);

    frameBegin(1'b1);
    sendLine(mkLine(2 * H, 1'b0), 1'b1);
    iCAM_HREF = 1'b1;
    #30;
    modelPix(8'h12, 8'h34, 0);
    camByte(8'h12); camByte(8'h34); camByte(8'h56);
    #100;
    checkEq("prerst_drain", 32'(qA.size()), 0);
    #3 iRST_N = 1'b0;
    #12;
    checkEq("mrst_valid", 32'(oPIX_VALID), 0);
    checkEq("mrst_addr", 32'(oPIX_ADDR), 0);
    checkEq("mrst_data", 32'(oPIX_DATA), 0);
    iRST_N = 1'b1;
    s0 = nValid; d0 = nDone; f0 = nStart;
    camByte(8'h78); camByte(8'h9A); camByte(8'hBC);
    #10 iCAM_HREF = 1'b0;
    #60;
    for (int l = 0; l < 2; l++) sendLine(mkLine(2 * H, 1'b0), 1'b0);
    frameEnd();
    checkEq("mrst_nostrobe", 32'(nValid - s0), 0);
    checkEq("mrst_nodone", 32'(nDone - d0), 0);
    checkEq("mrst_nostart", 32'(nStart - f0), 0);
    fullFrame(H, 1'b0, 1'b1);
    checkEq("postrst_drain", 32'(qA.size()), 0);
    checkEq("postrst_last", 32'(lastAddr), 32'(LIMIT));

    $display("Result: errors=%0d of %0d checks", nErrs, nChecks);
    $finish;
  end

endmodule
